serial_alu_sequencer: RTL

- Bit-serial controller that sits directly upstream and downstream of the 1-bit ALU bitslice.
- Takes a WIDTH-bit operation request and drives the slice one bit per clock, LSB first.
- Stores the slice's carry in a flop between bits and shifts the slice's sum back into a result register.
- Reports the result word plus carry/overflow/zero flags through a start/busy/done handshake.

---
 rtl/serial_alu_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial controller for a 1-bit ALU slice: feeds operands LSB first,
// chains the carry through a flop and reassembles the result with flags.
module serial_alu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow,
    output logic             zero,
    output logic [2:0]       bs_control,
    output logic             bs_a,
    output logic             bs_b,
    output logic             bs_carryin,
    input  logic             bs_sum,
    input  logic             bs_carryout
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             run_c;
    logic             arith_c;

    assign run_c   = (state_q == ST_RUN);
    assign arith_c = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Slice drive comes straight from flops, gated to zero outside RUN
    assign bs_control = run_c ? op_q  : 3'b000;
    assign bs_a       = run_c & a_q[0];
    assign bs_b       = run_c & b_q[0];
    assign bs_carryin = run_c & cy_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = res_q;
    assign carry_flag = carry_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    op_d    = op;
                    a_d     = opa;
                    b_d     = opb;
                    cnt_d   = '0;
                    cy_d    = (op == OP_SUB);
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                res_d  = {bs_sum, res_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                cy_d   = bs_carryout;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last bit: carry in/out of the MSB decide the arithmetic flags
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    carry_d = arith_c & bs_carryout;
                    ovf_d   = arith_c & (cy_q ^ bs_carryout);
                    zero_d  = (res_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule
